pc_gen: RTL and testbench
=========================

PC_GEN -- requirements
Module: pc_gen

Interface
REQ-001 SHALL have parameter XLEN, default 32, PC width in bits.
REQ-002 SHALL have parameter RESET_VEC, default 32'h8000_0000, first fetch address after reset.
REQ-003 SHALL have parameter BTB_DEPTH, default 4, BTB entries; power of two, at least 2.
REQ-004 SHALL have port clk, input, 1, clock; all state updates on its rising edge.
REQ-005 SHALL have port rst, input, 1, reset; synchronous, active-high.
REQ-006 SHALL have port trap_en, input, 1, trap/exception redirect request.
REQ-007 SHALL have port trap_pc, input, XLEN, trap target.
REQ-008 SHALL have port redirect_en, input, 1, branch/jump resolution redirect.
REQ-009 SHALL have port redirect_pc, input, XLEN, redirect target.
REQ-010 SHALL have port halt_req, input, 1, request to stop fetching.
REQ-011 SHALL have port fetch_ready, input, 1, consumer accepts fetch_pc.
REQ-012 SHALL have port fetch_valid, output, 1, fetch_pc is valid.
REQ-013 SHALL have port fetch_pc, output, XLEN, address to fetch.
REQ-014 SHALL have port pred_taken, output, 1, fetch_pc hit in BTB.
REQ-015 SHALL have port btb_upd_en, input, 1, BTB write strobe.
REQ-016 SHALL have port btb_upd_pc, input, XLEN, branch PC to record.
REQ-017 SHALL have port btb_upd_tgt, input, XLEN, taken target to record.

Function
REQ-018 SHALL implement FSM states BOOT, RUN and HALT.
REQ-019 SHALL enter BOOT on reset and move BOOT->RUN unconditionally one cycle later, with fetch_valid=0 in BOOT.
REQ-020 SHALL drive fetch_valid=1 in RUN and 0 in HALT.
REQ-021 SHALL move RUN->HALT when halt_req=1 and no trap/redirect arrives that cycle; halt takes effect the next cycle.
REQ-022 SHALL move HALT->RUN on trap_en or redirect_en, and the new target SHALL be fetch_pc in the next cycle.
REQ-023 SHALL order next-PC priority as: trap_pc > redirect_pc > BTB target (when pred_taken and handshake) > fetch_pc+4 (when handshake) > hold.
REQ-024 SHALL define handshake as fetch_valid & fetch_ready.
REQ-025 SHALL hold fetch_pc stable while fetch_valid=1 and fetch_ready=0, except when a trap/redirect overrides it.
REQ-026 SHALL apply trap and redirect independently of fetch_ready, with one-cycle latency.
REQ-027 SHALL clear bits [1:0] of any loaded target.
REQ-028 SHALL compute fetch_pc+4 modulo 2^XLEN, so all-ones-minus-3 wraps to 0.
REQ-029 SHALL take halt_req=1 together with redirect_en=1 as redirect-then-run: the redirect wins and state stays RUN.

Reset
REQ-030 SHALL, while rst=1, set fetch_pc=RESET_VEC, fetch_valid=0, pred_taken=0, state=BOOT, and clear all BTB valid bits.
REQ-031 SHALL discard any in-flight request that coincides with rst; rst dominates every input.

Configuration
REQ-032 SHALL use macro PC_GEN_BTB_EN; when defined, build a direct-mapped BTB.
REQ-033 SHALL index the BTB with pc[2 +: log2(BTB_DEPTH)], store the remaining upper bits as tag, and keep one valid bit per entry.
REQ-034 SHALL make BTB lookup combinational on fetch_pc; pred_taken = entry valid & tag match.
REQ-035 SHALL commit a BTB update at the clock edge; a same-cycle lookup of that entry sees the old contents.
REQ-036 SHALL, without PC_GEN_BTB_EN, tie pred_taken=0, ignore the btb_upd_* ports, and instantiate no BTB storage.

Structure
REQ-037 SHALL put the state enum (BOOT/RUN/HALT) and the default reset-vector constant in shared package pc_gen_pkg.
REQ-038 SHALL implement the BTB as sub-module pc_gen_btb, instantiated only under PC_GEN_BTB_EN.

Verification
REQ-039 SHALL cover: rst 2 cycles, release, fetch_ready=1 -> fetch_valid 0 one cycle, then fetch_pc 0x80000000, 0x80000004, 0x80000008.
REQ-040 SHALL cover: fetch_ready=0 for 3 cycles at 0x80000008 -> fetch_pc holds; no-handshake cycles give no increment.
REQ-041 SHALL cover: trap_en=1 trap_pc=0x100 and redirect_en=1 redirect_pc=0x200 in the same cycle -> next fetch_pc=0x100; redirect_pc=0x203 alone -> 0x200.
REQ-042 SHALL cover: halt_req=1 -> fetch_valid=0 next cycle and pc frozen; redirect_en pc=0x400 -> RUN, fetch_pc=0x400, valid=1.
REQ-043 SHALL cover: XLEN=32, fetch_pc=0xFFFFFFFC with handshake -> fetch_pc=0x00000000.
REQ-044 SHALL cover, with PC_GEN_BTB_EN: update 0x80000010->0x80000100, then fetch reaches 0x80000010 -> pred_taken=1, next fetch_pc=0x80000100; after rst -> pred_taken=0.

Source files
------------

// File: rtl/pc_gen_pkg.sv
// Shared types and constants for the program-counter generator.
package pc_gen_pkg;

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } pc_state_e;

  localparam logic [31:0] RESET_VEC_DEFAULT = 32'h8000_0000;

endpackage

// File: rtl/pc_gen_btb.sv
// Direct-mapped branch target buffer: combinational lookup, write at the clock edge.
module pc_gen_btb #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned DEPTH = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [XLEN-1:0] lookup_pc,
  output logic            hit_c,
  output logic [XLEN-1:0] tgt_c,
  input  logic            upd_en,
  input  logic [XLEN-1:0] upd_pc,
  input  logic [XLEN-1:0] upd_tgt
);

  localparam int unsigned IDX_W = $clog2(DEPTH);
  localparam int unsigned TAG_W = XLEN - 2 - IDX_W;

  logic [DEPTH-1:0] valid_q;
  logic [TAG_W-1:0] tag_q [DEPTH];
  logic [XLEN-1:0]  tgt_q [DEPTH];
  logic [IDX_W-1:0] rd_idx;
  logic [IDX_W-1:0] wr_idx;
  logic             unused_lo;

  assign rd_idx    = lookup_pc[2 +: IDX_W];
  assign wr_idx    = upd_pc[2 +: IDX_W];
  assign unused_lo = ^{lookup_pc[1:0], upd_pc[1:0]};

  assign hit_c = valid_q[rd_idx] && (tag_q[rd_idx] == lookup_pc[XLEN-1 -: TAG_W]);
  assign tgt_c = tgt_q[rd_idx];

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= '0;
    end else if (upd_en) begin
      valid_q[wr_idx] <= 1'b1;
    end
  end

  // Payload needs no reset: it is qualified by valid_q.
  always_ff @(posedge clk) begin
    if (upd_en) begin
      tag_q[wr_idx] <= upd_pc[XLEN-1 -: TAG_W];
      tgt_q[wr_idx] <= upd_tgt;
    end
  end

endmodule

// File: rtl/pc_gen.sv
// Fetch program-counter generator with trap/redirect/halt control.
// Optional branch target buffer enabled by defining PC_GEN_BTB_EN.
module pc_gen
  import pc_gen_pkg::*;
#(
  parameter int unsigned     XLEN      = 32,
  parameter logic [XLEN-1:0] RESET_VEC = XLEN'(RESET_VEC_DEFAULT),
  parameter int unsigned     BTB_DEPTH = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            trap_en,
  input  logic [XLEN-1:0] trap_pc,
  input  logic            redirect_en,
  input  logic [XLEN-1:0] redirect_pc,
  input  logic            halt_req,
  input  logic            fetch_ready,
  output logic            fetch_valid,
  output logic [XLEN-1:0] fetch_pc,
  output logic            pred_taken,
  input  logic            btb_upd_en,
  input  logic [XLEN-1:0] btb_upd_pc,
  input  logic [XLEN-1:0] btb_upd_tgt
);

  localparam logic [XLEN-1:0] ALIGN_MASK = ~XLEN'(3);

  pc_state_e       state;
  logic            handshake;
  logic [XLEN-1:0] btb_tgt;
  logic [XLEN-1:0] pc_nxt;

  assign handshake = fetch_valid & fetch_ready;

`ifdef PC_GEN_BTB_EN
  pc_gen_btb #(
    .XLEN  (XLEN),
    .DEPTH (BTB_DEPTH)
  ) u_btb (
    .clk       (clk),
    .rst       (rst),
    .lookup_pc (fetch_pc),
    .hit_c     (pred_taken),
    .tgt_c     (btb_tgt),
    .upd_en    (btb_upd_en),
    .upd_pc    (btb_upd_pc),
    .upd_tgt   (btb_upd_tgt)
  );
`else
  localparam int unsigned UNUSED_BTB_DEPTH = BTB_DEPTH;
  logic unused_btb;
  assign unused_btb = ^{btb_upd_en, btb_upd_pc, btb_upd_tgt};
  assign pred_taken = 1'b0;
  assign btb_tgt    = '0;
`endif

  // Next-PC priority: trap, redirect, predicted target, sequential, hold.
  always_comb begin
    pc_nxt = fetch_pc;
    if (trap_en) begin
      pc_nxt = trap_pc & ALIGN_MASK;
    end else if (redirect_en) begin
      pc_nxt = redirect_pc & ALIGN_MASK;
    end else if (handshake && pred_taken) begin
      pc_nxt = btb_tgt & ALIGN_MASK;
    end else if (handshake) begin
      pc_nxt = fetch_pc + XLEN'(4);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= BOOT;
      fetch_pc    <= RESET_VEC;
      fetch_valid <= 1'b0;
    end else begin
      fetch_pc <= pc_nxt;
      case (state)
        BOOT: begin
          state       <= RUN;
          fetch_valid <= 1'b1;
        end
        RUN: begin
          // A same-cycle trap or redirect cancels the halt request.
          if (halt_req && !trap_en && !redirect_en) begin
            state       <= HALT;
            fetch_valid <= 1'b0;
          end
        end
        HALT: begin
          if (trap_en || redirect_en) begin
            state       <= RUN;
            fetch_valid <= 1'b1;
          end
        end
        default: begin
          state       <= BOOT;
          fetch_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pc_gen.sv
// Directed table-driven checks for pc_gen, plus a BTB sequence when PC_GEN_BTB_EN is defined.
module tb_pc_gen;

  logic        clk = 1'b0;
  logic        rst;
  logic        trap_en;
  logic [31:0] trap_pc;
  logic        redirect_en;
  logic [31:0] redirect_pc;
  logic        halt_req;
  logic        fetch_ready;
  logic        fetch_valid;
  logic [31:0] fetch_pc;
  logic        pred_taken;
  logic        btb_upd_en;
  logic [31:0] btb_upd_pc;
  logic [31:0] btb_upd_tgt;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  pc_gen dut (
    .clk         (clk),
    .rst         (rst),
    .trap_en     (trap_en),
    .trap_pc     (trap_pc),
    .redirect_en (redirect_en),
    .redirect_pc (redirect_pc),
    .halt_req    (halt_req),
    .fetch_ready (fetch_ready),
    .fetch_valid (fetch_valid),
    .fetch_pc    (fetch_pc),
    .pred_taken  (pred_taken),
    .btb_upd_en  (btb_upd_en),
    .btb_upd_pc  (btb_upd_pc),
    .btb_upd_tgt (btb_upd_tgt)
  );

  typedef struct {
    logic        rst;
    logic        trap_en;
    logic [31:0] trap_pc;
    logic        redirect_en;
    logic [31:0] redirect_pc;
    logic        halt_req;
    logic        fetch_ready;
    logic        exp_valid;
    logic [31:0] exp_pc;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic r, input logic te, input logic [31:0] tp,
                     input logic re, input logic [31:0] rp, input logic h,
                     input logic rdy, input logic ev, input logic [31:0] epc);
    vec_t v;
    v.rst = r; v.trap_en = te; v.trap_pc = tp; v.redirect_en = re;
    v.redirect_pc = rp; v.halt_req = h; v.fetch_ready = rdy;
    v.exp_valid = ev; v.exp_pc = epc;
    vecs.push_back(v);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic idle_inputs();
    rst = 1'b0; trap_en = 1'b0; trap_pc = '0; redirect_en = 1'b0; redirect_pc = '0;
    halt_req = 1'b0; fetch_ready = 1'b0;
    btb_upd_en = 1'b0; btb_upd_pc = '0; btb_upd_tgt = '0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    idle_inputs();
    rst = 1'b1;

    //   rst te tpc           re rpc           h  rdy  valid pc
    add(1, 0, 32'h0,        0, 32'h0,        0, 1,   0, 32'h8000_0000);
    add(1, 0, 32'h0,        0, 32'h0,        0, 1,   0, 32'h8000_0000);
    add(0, 0, 32'h0,        0, 32'h0,        0, 1,   1, 32'h8000_0000);
    add(0, 0, 32'h0,        0, 32'h0,        0, 1,   1, 32'h8000_0004);
    add(0, 0, 32'h0,        0, 32'h0,        0, 1,   1, 32'h8000_0008);
    add(0, 0, 32'h0,        0, 32'h0,        0, 0,   1, 32'h8000_0008);
    add(0, 0, 32'h0,        0, 32'h0,        0, 0,   1, 32'h8000_0008);
    add(0, 0, 32'h0,        0, 32'h0,        0, 0,   1, 32'h8000_0008);
    add(0, 1, 32'h100,      1, 32'h200,      0, 0,   1, 32'h0000_0100);
    add(0, 0, 32'h0,        1, 32'h203,      0, 0,   1, 32'h0000_0200);
    add(0, 0, 32'h0,        0, 32'h0,        0, 1,   1, 32'h0000_0204);
    add(0, 0, 32'h0,        0, 32'h0,        1, 0,   0, 32'h0000_0204);
    add(0, 0, 32'h0,        0, 32'h0,        0, 1,   0, 32'h0000_0204);
    add(0, 0, 32'h0,        0, 32'h0,        0, 1,   0, 32'h0000_0204);
    add(0, 0, 32'h0,        1, 32'h400,      0, 1,   1, 32'h0000_0400);
    add(0, 0, 32'h0,        1, 32'h500,      1, 1,   1, 32'h0000_0500);
    add(0, 0, 32'h0,        0, 32'h0,        0, 1,   1, 32'h0000_0504);
    add(0, 1, 32'hFFFF_FFFF, 0, 32'h0,       0, 0,   1, 32'hFFFF_FFFC);
    add(0, 0, 32'h0,        0, 32'h0,        0, 1,   1, 32'h0000_0000);
    add(0, 0, 32'h0,        0, 32'h0,        0, 1,   1, 32'h0000_0004);
    add(0, 1, 32'h300,      0, 32'h0,        1, 1,   1, 32'h0000_0300);
    add(1, 1, 32'h700,      1, 32'h900,      1, 1,   0, 32'h8000_0000);
    add(0, 0, 32'h0,        0, 32'h0,        0, 0,   1, 32'h8000_0000);
    add(0, 0, 32'h0,        0, 32'h0,        1, 1,   0, 32'h8000_0004);
    add(0, 0, 32'h0,        0, 32'h0,        0, 1,   0, 32'h8000_0004);
    add(0, 1, 32'h12,       0, 32'h0,        0, 0,   1, 32'h0000_0010);

    for (int i = 0; i < vecs.size(); i++) begin
      rst         = vecs[i].rst;
      trap_en     = vecs[i].trap_en;
      trap_pc     = vecs[i].trap_pc;
      redirect_en = vecs[i].redirect_en;
      redirect_pc = vecs[i].redirect_pc;
      halt_req    = vecs[i].halt_req;
      fetch_ready = vecs[i].fetch_ready;
      step();
      check($sformatf("v%0d_valid", i), 32'(fetch_valid), 32'(vecs[i].exp_valid));
      check($sformatf("v%0d_pc", i), fetch_pc, vecs[i].exp_pc);
      check($sformatf("v%0d_pred", i), 32'(pred_taken), 32'h0);
    end

`ifdef PC_GEN_BTB_EN
    // BTB hit redirects the sequential stream; reset forgets the entry.
    idle_inputs();
    redirect_en = 1'b1; redirect_pc = 32'h8000_0008;
    btb_upd_en = 1'b1; btb_upd_pc = 32'h8000_0010; btb_upd_tgt = 32'h8000_0100;
    step();
    idle_inputs();
    fetch_ready = 1'b1;
    check("btb_pre_pc", fetch_pc, 32'h8000_0008);
    check("btb_pre_pred", 32'(pred_taken), 32'h0);
    step();
    step();
    check("btb_hit_pc", fetch_pc, 32'h8000_0010);
    check("btb_hit_pred", 32'(pred_taken), 32'h1);
    step();
    check("btb_tgt_pc", fetch_pc, 32'h8000_0100);
    check("btb_tgt_pred", 32'(pred_taken), 32'h0);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("btb_rst_pred", 32'(pred_taken), 32'h0);
    redirect_en = 1'b1; redirect_pc = 32'h8000_0010;
    step();
    redirect_en = 1'b0;
    check("btb_cleared_pc", fetch_pc, 32'h8000_0010);
    check("btb_cleared_pred", 32'(pred_taken), 32'h0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
